// File: rtl/bank_ram_1p_resp.sv
// Single-port bank RAM responder: lane-masked writes, 1-cycle registered reads held between
// reads, and a zero-clearing init sweep after every reset before requests are accepted.
module bank_ram_1p_resp #(
   parameter int unsigned ADDR_W = 7,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned MASK_W = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] io_addr,
   input  logic              io_rw,
   input  logic [DATA_W-1:0] io_wdata,
   input  logic [MASK_W-1:0] io_wmask,
   output logic [DATA_W-1:0] io_rdata,
   output logic              io_ready
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned LW    = DATA_W / MASK_W;

   typedef enum logic [0:0] {StInit, StRun} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              mem_we;
   logic              rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_bmask;
   logic [DATA_W-1:0] lane_bmask;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= StInit;
         init_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      if (state_q == StInit) begin
         init_cnt_d = init_cnt_q + ADDR_W'(1);
         if (init_cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_d = StRun;
         end
      end
   end

   always_comb begin
      lane_bmask = '0;
      for (int i = 0; i < int'(MASK_W); i++) begin
         lane_bmask[i*LW +: LW] = {LW{io_wmask[i]}};
      end
   end

   // The sweep write is built from constants only, so request inputs cannot reach memory in INIT.
   always_comb begin
      mem_we    = 1'b0;
      rd_en     = 1'b0;
      mem_addr  = io_addr;
      mem_wdata = io_wdata;
      mem_bmask = lane_bmask;
      unique case (state_q)
         StInit: begin
            mem_we    = 1'b1;
            mem_addr  = init_cnt_q;
            mem_wdata = '0;
            mem_bmask = '1;
         end
         StRun: begin
            mem_we = io_rw;
            rd_en  = ~io_rw;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset && mem_we) begin
         mem[mem_addr] <= (mem[mem_addr] & ~mem_bmask) | (mem_wdata & mem_bmask);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rdata_q <= '0;
      end else if (rd_en) begin
         rdata_q <= mem[io_addr];
      end
   end

   assign io_rdata = rdata_q;
   assign io_ready = (state_q == StRun);

endmodule

// File: tb/tb_bank_ram_1p_resp.sv
// Directed plus randomized bench for bank_ram_1p_resp, checked against an array-based
// reference model of the RAM, its init sweep and its held read register.
module tb_bank_ram_1p_resp;

   localparam int DEPTH = 128;

   logic       clock = 1'b0;
   logic       reset;
   logic [6:0] io_addr;
   logic       io_rw;
   logic [7:0] io_wdata;
   logic [3:0] io_wmask;
   logic [7:0] io_rdata;
   logic       io_ready;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [7:0] m_mem [DEPTH];
   logic [7:0] m_rdata;
   logic       m_ready;
   int         m_swept;

   bank_ram_1p_resp #(.ADDR_W(7), .DATA_W(8), .MASK_W(4)) dut (
      .clock   (clock),
      .reset   (reset),
      .io_addr (io_addr),
      .io_rw   (io_rw),
      .io_wdata(io_wdata),
      .io_wmask(io_wmask),
      .io_rdata(io_rdata),
      .io_ready(io_ready)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive request, advance model, compare both outputs 1 time unit after edge.
   task automatic cyc(input logic rst, input logic rw, input logic [6:0] addr,
                      input logic [7:0] wd, input logic [3:0] wm);
      reset    = rst;
      io_rw    = rw;
      io_addr  = addr;
      io_wdata = wd;
      io_wmask = wm;
      @(posedge clock);
      if (rst) begin
         m_swept = 0;
         m_ready = 1'b0;
         m_rdata = 8'h00;
      end else if (!m_ready) begin
         m_mem[m_swept] = 8'h00;
         m_swept++;
         if (m_swept == DEPTH) m_ready = 1'b1;
      end else if (rw) begin
         for (int i = 0; i < 4; i++) begin
            if (wm[i]) m_mem[addr][i*2 +: 2] = wd[i*2 +: 2];
         end
      end else begin
         m_rdata = m_mem[addr];
      end
      #1;
      chk("ready", {7'b0, io_ready}, {7'b0, m_ready});
      chk("rdata", io_rdata, m_rdata);
   endtask

   task automatic rnd_cyc();
      cyc(1'b0, 1'($urandom), 7'($urandom), 8'($urandom), 4'($urandom));
   endtask

   task automatic rd(input logic [6:0] addr);
      cyc(1'b0, 1'b0, addr, 8'h00, 4'h0);
   endtask

   task automatic wr(input logic [6:0] addr, input logic [7:0] wd, input logic [3:0] wm);
      cyc(1'b0, 1'b1, addr, wd, wm);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
      m_rdata = 8'h00;
      m_ready = 1'b0;
      m_swept = 0;

      // Reset then the sweep; random requests during INIT must be ignored
      cyc(1'b1, 1'b0, 7'd0, 8'h00, 4'h0);
      chk("reset_ready", {7'b0, io_ready}, 8'h00);
      chk("reset_rdata", io_rdata, 8'h00);
      for (int i = 0; i < DEPTH - 1; i++) rnd_cyc();
      chk("ready_low_127", {7'b0, io_ready}, 8'h00);
      rnd_cyc();
      chk("ready_high_128", {7'b0, io_ready}, 8'h01);
      rd(7'd0);   chk("clr_0", io_rdata, 8'h00);
      rd(7'd64);  chk("clr_64", io_rdata, 8'h00);
      rd(7'd127); chk("clr_127", io_rdata, 8'h00);

      // Full write, read back, then no-op cycles hold rdata
      wr(7'd5, 8'hA5, 4'hF);
      rd(7'd5);   chk("rd_a5", io_rdata, 8'hA5);
      for (int i = 0; i < 3; i++) wr(7'd9, 8'hFF, 4'h0);
      chk("hold_a5", io_rdata, 8'hA5);

      // Masked writes
      wr(7'd5, 8'h3C, 4'b0101);
      rd(7'd5);   chk("masked_b4", io_rdata, 8'hB4);
      wr(7'd5, 8'h00, 4'h0);
      rd(7'd5);   chk("nomask_b4", io_rdata, 8'hB4);

      // Back-to-back reads and a write between reads
      wr(7'd0, 8'h11, 4'hF);
      wr(7'd127, 8'h22, 4'hF);
      rd(7'd0);   chk("b2b_0", io_rdata, 8'h11);
      rd(7'd127); chk("b2b_127", io_rdata, 8'h22);
      rd(7'd0);   chk("b2b_0b", io_rdata, 8'h11);
      wr(7'd64, 8'h77, 4'hF);
      chk("wr_hold", io_rdata, 8'h11);
      rd(7'd64);  chk("rd_77", io_rdata, 8'h77);

      // Reset mid-RUN: sweep clears, writes during INIT ignored
      cyc(1'b1, 1'b0, 7'd0, 8'h00, 4'h0);
      chk("rrun_ready", {7'b0, io_ready}, 8'h00);
      chk("rrun_rdata", io_rdata, 8'h00);
      for (int i = 0; i < DEPTH; i++) wr(7'd3, 8'hFF, 4'hF);
      chk("rrun_ready_up", {7'b0, io_ready}, 8'h01);
      rd(7'd5);   chk("rrun_clr5", io_rdata, 8'h00);
      rd(7'd3);   chk("rrun_clr3", io_rdata, 8'h00);

      // Reset mid-INIT at cycle 60: sweep restarts from zero
      for (int i = 0; i < 20; i++) rnd_cyc();
      cyc(1'b1, 1'b0, 7'd0, 8'h00, 4'h0);
      for (int i = 0; i < 60; i++) wr(7'd3, 8'hFF, 4'hF);
      cyc(1'b1, 1'b0, 7'd0, 8'h00, 4'h0);
      for (int i = 0; i < DEPTH - 1; i++) wr(7'd3, 8'hFF, 4'hF);
      chk("rinit_low", {7'b0, io_ready}, 8'h00);
      wr(7'd3, 8'hFF, 4'hF);
      chk("rinit_high", {7'b0, io_ready}, 8'h01);
      rd(7'd3);   chk("rinit_clr3", io_rdata, 8'h00);

      // Randomized traffic on a narrow address window to force reuse
      for (int i = 0; i < 600; i++) begin
         logic [6:0] a;
         a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : {4'b0, 3'($urandom)};
         cyc(1'b0, 1'($urandom), a, 8'($urandom), 4'($urandom));
      end
      for (int i = 0; i < DEPTH; i++) rd(7'(i));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
